// File: rtl/sar_result_fifo.sv
// sar_result_fifo: captures SAR codes on eoc, optionally box-car averages them, and queues results in a show-ahead FIFO.
module sar_result_fifo #(
  parameter int DEPTH    = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     eoc,
  input  logic [7:0]               sar,
  input  logic                     avg_en,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = 8 + AVG_LOG2;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [7:0]          r_mem [DEPTH];
  logic [AW-1:0]       r_wp, r_rp;
  logic [AW:0]         r_cnt;
  logic [SW-1:0]       r_acc;
  logic [AVG_LOG2-1:0] r_scnt;
  logic                r_ovf;
  logic [SW-1:0]       w_sum;
  logic [7:0]          w_res;
  logic                w_push, w_pop, w_full, w_wr, w_drop;
  always_comb begin
    w_sum  = r_acc + SW'(sar);
    w_push = eoc & (~avg_en | (&r_scnt));
    w_res  = avg_en ? w_sum[AVG_LOG2 +: 8] : sar;
    w_pop  = out_valid & out_ready;
    w_full = r_cnt == FULL;
    w_wr   = w_push & (~w_full | w_pop);
    w_drop = w_push & w_full & ~w_pop;
  end
  assign out_valid = r_cnt != '0;
  assign out_data  = out_valid ? r_mem[r_rp] : '0;
  assign count     = r_cnt;
  assign overflow  = r_ovf;
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= w_res;
  // scnt wraps to 0 on its own after the last sample of a window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_scnt <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_acc  <= (!avg_en || (eoc && &r_scnt)) ? '0 : eoc ? w_sum : r_acc;
      r_scnt <= !avg_en ? '0 : eoc ? r_scnt + AVG_LOG2'(1) : r_scnt;
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt  <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      r_ovf  <= w_drop | (r_ovf & ~clr_ovf);
    end
  end
endmodule

// File: tb/tb_sar_result_fifo.sv
// tb_sar_result_fifo: directed stimulus with a scoreboard queue drained by a separate pop monitor.
module tb_sar_result_fifo;
  logic       clk = 1'b0, rst = 1'b1, eoc = 1'b0, avg_en = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
  logic [7:0] sar = 8'd0;
  logic [7:0] out_data;
  logic       out_valid, overflow;
  logic [3:0] count;
  logic [7:0] exp_q [$];
  int n_chk = 0, n_fail = 0;

  sar_result_fifo #(.DEPTH(8), .AVG_LOG2(2)) dut (
    .clk(clk), .rst(rst), .eoc(eoc), .sar(sar), .avg_en(avg_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // drive one cycle of inputs, return #1 after the sampling edge
  task automatic cyc(input logic e, input logic [7:0] s, input logic a, input logic r, input logic c);
    eoc = e; sar = s; avg_en = a; out_ready = r; clr_ovf = c;
    @(posedge clk);
    #1;
    eoc = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, avg_en, 1'b1, 1'b0);
  endtask

  // pop monitor: a handshake seen mid-cycle pops at the next edge
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pop", int'(out_data), -1);
      else chk("pop_head", int'(out_data), int'(exp_q.pop_front()));
    end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_ovf", int'(overflow), 0);
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    chk("ready_empty_count", int'(count), 0);

    foreach (exp_q[i]) ;
    begin
      logic [7:0] v [3];
      v = '{8'hA5, 8'h3C, 8'hFF};
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back(v[i]);
        cyc(1'b1, v[i], 1'b0, 1'b0, 1'b0);
      end
    end
    chk("pass_count", int'(count), 3);
    chk("pass_head", int'(out_data), 8'hA5);
    drain(3);
    chk("pass_empty_valid", int'(out_valid), 0);
    chk("pass_empty_data", int'(out_data), 0);

    cyc(1'b1, 8'd10, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'd11, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'd12, 1'b1, 1'b0, 1'b0);
    chk("avg_partial_count", int'(count), 0);
    exp_q.push_back(8'd11);
    cyc(1'b1, 8'd14, 1'b1, 1'b0, 1'b0);
    chk("avg_count", int'(count), 1);
    chk("avg_head", int'(out_data), 11);
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    chk("avg_ff_count", int'(count), 2);
    drain(2);

    cyc(1'b1, 8'd200, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'd200, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'd4, 1'b1, 1'b0, 1'b0);
    chk("abort_partial_count", int'(count), 0);
    exp_q.push_back(8'd4);
    cyc(1'b1, 8'd4, 1'b1, 1'b0, 1'b0);
    chk("abort_count", int'(count), 1);
    drain(1);

    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(8'(i));
      cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    end
    chk("full_count", int'(count), 8);
    chk("full_no_ovf", int'(overflow), 0);
    cyc(1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
    chk("ovf_count", int'(count), 8);
    chk("ovf_set", int'(overflow), 1);
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", int'(overflow), 0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    chk("ovf_set_wins", int'(overflow), 1);
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr2", int'(overflow), 0);
    exp_q.push_back(8'h5A);
    cyc(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
    chk("full_pushpop_count", int'(count), 8);
    chk("full_pushpop_ovf", int'(overflow), 0);
    chk("full_pushpop_head", int'(out_data), 2);
    drain(8);
    chk("drain_count", int'(count), 0);
    chk("drain_valid", int'(out_valid), 0);

    cyc(1'b1, 8'd50, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'd100, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", int'(count), 1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_data", int'(out_data), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'd8, 1'b1, 1'b0, 1'b0);
    chk("post_rst_partial_count", int'(count), 0);
    exp_q.push_back(8'd8);
    cyc(1'b1, 8'd8, 1'b1, 1'b0, 1'b0);
    chk("post_rst_count", int'(count), 1);
    drain(1);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("final_valid", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
